// File: rtl/timer_irq.sv
// Multi-channel bus timer: one shared prescaler drives NrChannels counters.
// Each channel has a compare register, one-shot/periodic mode and a maskable pending interrupt.
module timer_irq #(
   parameter int NrChannels    = 4,
   parameter int DataWidth     = 32,
   parameter int AddrWidth     = 32,
   parameter int PrescaleWidth = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [AddrWidth-1:0]  addr_i,
   input  logic [DataWidth-1:0]  wdata_i,
   output logic [DataWidth-1:0]  rdata_o,
   output logic [NrChannels-1:0] irq_o,
   output logic                  irq_any_o
);

   localparam logic [7:0] PrescaleWord = 8'h40;
   localparam logic [7:0] PendAllWord  = 8'h41;

   logic [7:0]               word;
   logic                     wr;
   logic                     rd;
   logic                     prescale_wr;
   logic                     tick;
   logic [PrescaleWidth-1:0] prescale_reg;
   logic [PrescaleWidth-1:0] pc_reg;
   logic [DataWidth-1:0]     cnt_all [NrChannels];
   logic [DataWidth-1:0]     cmp_all [NrChannels];
   logic [2:0]               ctrl_all [NrChannels];
   logic [NrChannels-1:0]    pend_all;
   logic [DataWidth-1:0]     rdata_next;
   logic                     unused_addr;

   // The bus has already selected this device; only the word index matters here.
   assign word        = addr_i[9:2];
   assign unused_addr = ^{addr_i[AddrWidth-1:10], addr_i[1:0]};

   assign wr          = req_i && we_i;
   assign rd          = req_i && !we_i;
   assign prescale_wr = wr && (word == PrescaleWord);
   assign tick        = (pc_reg == prescale_reg) && !prescale_wr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prescale_reg <= '0;
         pc_reg       <= '0;
      end else if (prescale_wr) begin
         prescale_reg <= wdata_i[PrescaleWidth-1:0];
         pc_reg       <= '0;
      end else if (pc_reg == prescale_reg) begin
         pc_reg <= '0;
      end else begin
         pc_reg <= pc_reg + PrescaleWidth'(1);
      end
   end

   for (genvar gi = 0; gi < NrChannels; gi++) begin : g_chan
      logic [DataWidth-1:0] cnt_reg;
      logic [DataWidth-1:0] cmp_reg;
      logic [2:0]           ctrl_reg;
      logic                 pend_reg;
      logic                 sel;
      logic                 match;
      logic                 clr;

      assign sel   = wr && (word[7:2] == 6'(gi));
      assign match = tick && ctrl_reg[0] && (cnt_reg == cmp_reg);
      assign clr   = sel && (word[1:0] == 2'd3) && wdata_i[0];

      // Software writes come last so they override the tick update of CNT/CTRL.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            cnt_reg  <= '0;
            cmp_reg  <= '0;
            ctrl_reg <= '0;
            pend_reg <= 1'b0;
         end else begin
            if (tick && ctrl_reg[0]) begin
               if (cnt_reg == cmp_reg) begin
                  if (ctrl_reg[1]) cnt_reg <= '0;
                  else             ctrl_reg[0] <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg + DataWidth'(1);
               end
            end
            pend_reg <= match | (pend_reg & ~clr);
            if (sel) begin
               case (word[1:0])
                  2'd0:    ctrl_reg <= wdata_i[2:0];
                  2'd1:    cmp_reg  <= wdata_i;
                  2'd2:    cnt_reg  <= wdata_i;
                  default: ;
               endcase
            end
         end
      end

      assign cnt_all[gi]  = cnt_reg;
      assign cmp_all[gi]  = cmp_reg;
      assign ctrl_all[gi] = ctrl_reg;
      assign pend_all[gi] = pend_reg;
      assign irq_o[gi]    = pend_reg & ctrl_reg[2];
   end

   assign irq_any_o = |irq_o;

   always_comb begin
      rdata_next = '0;
      for (int i = 0; i < NrChannels; i++) begin
         if (word[7:2] == 6'(i)) begin
            case (word[1:0])
               2'd0:    rdata_next = DataWidth'(ctrl_all[i]);
               2'd1:    rdata_next = cmp_all[i];
               2'd2:    rdata_next = cnt_all[i];
               default: rdata_next = DataWidth'(pend_all[i]);
            endcase
         end
      end
      if (word == PrescaleWord)     rdata_next = DataWidth'(prescale_reg);
      else if (word == PendAllWord) rdata_next = DataWidth'(pend_all);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)   rdata_o <= '0;
      else if (rd) rdata_o <= rdata_next;
   end

endmodule

// File: tb/tb_timer_irq.sv
// Bench for timer_irq: directed bus traffic, a cycle model derived from the register rules,
// and per-cycle comparison of rdata/irq outputs plus hand-computed literal checks.
module tb_timer_irq;

   localparam int NCH = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            req;
   logic            we;
   logic [31:0]     addr;
   logic [31:0]     wdata;
   logic [31:0]     rdata;
   logic [NCH-1:0]  irq;
   logic            irq_any;

   int n_checks = 0;
   int n_fail   = 0;

   timer_irq #(.NrChannels(NCH), .DataWidth(32), .AddrWidth(32), .PrescaleWidth(16)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .rdata_o(rdata), .irq_o(irq), .irq_any_o(irq_any)
   );

   always #5 clk = ~clk;

   // Model state: registers as software sees them, prescaler as elapsed cycles.
   logic [31:0] m_cnt [NCH];
   logic [31:0] m_cmp [NCH];
   logic [2:0]  m_ctrl [NCH];
   logic [NCH-1:0] m_pend;
   logic [15:0] m_pre;
   int          m_t;
   logic [31:0] m_rdata;
   bit          seen = 1'b0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(logic [31:0] a);
      int w;
      w = int'(a[9:2]);
      if (w < 4 * NCH) begin
         case (w % 4)
            0: return {29'b0, m_ctrl[w / 4]};
            1: return m_cmp[w / 4];
            2: return m_cnt[w / 4];
            default: return {31'b0, m_pend[w / 4]};
         endcase
      end
      if (w == 64) return {16'b0, m_pre};
      if (w == 65) return {{(32 - NCH){1'b0}}, m_pend};
      return 32'h0;
   endfunction

   always @(posedge clk) begin
      int  w;
      bit  tick;
      bit  fired;
      seen = 1'b1;
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_cmp[i] = 0; m_ctrl[i] = 0;
         end
         m_pend = 0; m_pre = 0; m_t = 0; m_rdata = 0;
      end else begin
         w = int'(addr[9:2]);
         if (req && !we) m_rdata = model_read(addr);
         tick = !(req && we && w == 64) && ((m_t % (int'(m_pre) + 1)) == int'(m_pre));
         for (int i = 0; i < NCH; i++) begin
            fired = tick && m_ctrl[i][0] && (m_cnt[i] == m_cmp[i]);
            if (tick && m_ctrl[i][0]) begin
               if (fired) begin
                  if (m_ctrl[i][1]) m_cnt[i] = 0;
                  else m_ctrl[i][0] = 1'b0;
               end else begin
                  m_cnt[i] = m_cnt[i] + 1;
               end
            end
            if (req && we && w < 4 * NCH && w / 4 == i) begin
               case (w % 4)
                  0: m_ctrl[i] = wdata[2:0];
                  1: m_cmp[i] = wdata;
                  2: m_cnt[i] = wdata;
                  default: if (wdata[0]) m_pend[i] = 1'b0;
               endcase
            end
            if (fired) m_pend[i] = 1'b1;
         end
         if (req && we && w == 64) begin
            m_pre = wdata[15:0];
            m_t = 0;
         end else begin
            m_t++;
         end
      end
   end

   always @(negedge clk) begin
      logic [NCH-1:0] e;
      if (seen) begin
         for (int i = 0; i < NCH; i++) e[i] = m_pend[i] & m_ctrl[i][2];
         chk("model_irq", {{(32 - NCH){1'b0}}, irq}, {{(32 - NCH){1'b0}}, e});
         chk("model_irq_any", {31'b0, irq_any}, {31'b0, |e});
         chk("model_rdata", rdata, m_rdata);
      end
   end

   task automatic wr(logic [31:0] a, logic [31:0] d);
      req = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
   endtask

   task automatic rd_chk(string name, logic [31:0] a, logic [31:0] exp);
      req = 1'b1; we = 1'b0; addr = a; wdata = 32'h0;
      @(negedge clk);
      req = 1'b0;
      chk(name, rdata, exp);
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_irq", {28'b0, irq}, 32'h0);
      chk("rst_irq_any", {31'b0, irq_any}, 32'h0);
      for (int a = 0; a < 'h40; a += 4) rd_chk("rst_read", 32'(a), 32'h0);
      rd_chk("rst_prescale", 32'h100, 32'h0);
      rd_chk("rst_pend_all", 32'h104, 32'h0);

      // ch0 periodic, CMP=5, prescale 0
      wr(32'h100, 0);
      wr(32'h4, 5);
      wr(32'h0, 7);
      repeat (5) @(negedge clk);
      chk("ch0_no_irq_yet", {28'b0, irq}, 32'h0);
      rd_chk("ch0_cnt_5", 32'h8, 32'h5);
      chk("ch0_irq_set", {28'b0, irq}, 32'h1);
      chk("ch0_irq_any", {31'b0, irq_any}, 32'h1);
      rd_chk("ch0_cnt_wrap0", 32'h8, 32'h0);
      rd_chk("ch0_cnt_1", 32'h8, 32'h1);
      wr(32'hC, 1);
      chk("ch0_irq_cleared", {28'b0, irq}, 32'h0);
      repeat (2) @(negedge clk);
      wr(32'hC, 1);
      chk("ch0_set_beats_clear", {28'b0, irq}, 32'h1);
      wr(32'h8, 32'h10);
      rd_chk("ch0_cnt_write_wins", 32'h8, 32'h10);
      wr(32'h0, 0);
      wr(32'hC, 1);
      chk("ch0_off", {28'b0, irq}, 32'h0);

      // ch1 one-shot, prescale 3
      wr(32'h100, 3);
      wr(32'h14, 2);
      wr(32'h10, 5);
      rd_chk("ch1_cnt_a", 32'h18, 32'h0);
      rd_chk("ch1_cnt_b", 32'h18, 32'h0);
      rd_chk("ch1_cnt_c", 32'h18, 32'h1);
      repeat (6) @(negedge clk);
      chk("ch1_before_match", {28'b0, irq}, 32'h0);
      @(negedge clk);
      chk("ch1_match_irq", {28'b0, irq}, 32'h2);
      rd_chk("ch1_en_cleared", 32'h10, 32'h4);
      rd_chk("ch1_cnt_hold", 32'h18, 32'h2);
      wr(32'h1C, 1);
      repeat (20) @(negedge clk);
      chk("ch1_no_repend", {28'b0, irq}, 32'h0);
      rd_chk("ch1_stat_0", 32'h1C, 32'h0);
      rd_chk("ch1_cnt_still_2", 32'h18, 32'h2);

      // ch2 wrap-around
      wr(32'h100, 0);
      wr(32'h28, 32'hFFFF_FFFF);
      wr(32'h24, 1);
      wr(32'h20, 1);
      rd_chk("ch2_cnt_max", 32'h28, 32'hFFFF_FFFF);
      rd_chk("ch2_cnt_wrap", 32'h28, 32'h0);
      rd_chk("ch2_stat_pre", 32'h2C, 32'h0);
      rd_chk("ch2_stat_set", 32'h2C, 32'h1);
      rd_chk("pend_all", 32'h104, 32'h4);
      rd_chk("ch2_en_cleared", 32'h20, 32'h0);
      wr(32'h2C, 1);

      // ch3 periodic CMP=0, then reset mid-count
      wr(32'h4, 32'h55);
      wr(32'h30, 7);
      chk("ch3_pre_irq", {28'b0, irq}, 32'h0);
      @(negedge clk);
      chk("ch3_irq", {28'b0, irq}, 32'h8);
      chk("ch3_irq_any", {31'b0, irq_any}, 32'h1);
      rd_chk("ch3_cnt_stays0", 32'h38, 32'h0);
      rd_chk("ch3_ctrl", 32'h30, 32'h7);
      rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h34; wdata = 32'h9;
      @(negedge clk);
      rst = 1'b0; req = 1'b0; we = 1'b0;
      chk("mid_rst_rdata", rdata, 32'h0);
      chk("mid_rst_irq", {28'b0, irq}, 32'h0);
      chk("mid_rst_irq_any", {31'b0, irq_any}, 32'h0);
      rd_chk("mid_rst_ctrl3", 32'h30, 32'h0);
      rd_chk("mid_rst_cmp3", 32'h34, 32'h0);
      rd_chk("mid_rst_cmp0", 32'h4, 32'h0);
      rd_chk("mid_rst_pend_all", 32'h104, 32'h0);

      // Unmapped and out-of-range offsets
      wr(32'h200, 32'hFFFF_FFFF);
      wr(32'h40, 32'h7);
      wr(32'h108, 32'h1);
      rd_chk("unmapped_200", 32'h200, 32'h0);
      rd_chk("unmapped_40", 32'h40, 32'h0);
      rd_chk("unmapped_108", 32'h108, 32'h0);
      rd_chk("no_alias_ctrl0", 32'h0, 32'h0);
      rd_chk("no_alias_cnt0", 32'h8, 32'h0);
      rd_chk("no_alias_prescale", 32'h100, 32'h0);
      chk("final_irq", {28'b0, irq}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
